// File: rtl/freq_gen_value_if.sv
// Host-side bundle for the programmable square-wave generator.
// freq_load is a one-cycle strobe with no back-pressure; edge_cnt_vld is a one-cycle qualifier for edge_cnt.
interface freq_gen_value_if;
  logic [31:0] freq_hz;
  logic        freq_load;
  logic        clk_gen;
  logic        rise_pulse;
  logic [31:0] freq_active_hz;
  logic        update_pending;
  logic        clamp;
  logic [31:0] edge_cnt;
  logic        edge_cnt_vld;
  logic        state_dbg;

  modport master (
    output freq_hz, freq_load,
    input  clk_gen, rise_pulse, freq_active_hz, update_pending, clamp,
           edge_cnt, edge_cnt_vld, state_dbg
  );

  modport slave (
    input  freq_hz, freq_load,
    output clk_gen, rise_pulse, freq_active_hz, update_pending, clamp,
           edge_cnt, edge_cnt_vld, state_dbg
  );
endinterface

// File: rtl/freq_gen_value.sv
// NCO-based square-wave generator with glitch-free frequency updates at the
// falling (1->0) period boundary, plus a rising-edge counter over a fixed window.
module freq_gen_value #(
  parameter int unsigned SYS_PRD_NS   = 10,
  parameter int unsigned MEAS_WIN_CYC = 1000000000 / SYS_PRD_NS
) (
  input  logic              clk,
  input  logic              rst_n,
  freq_gen_value_if.slave   bus
);
  localparam logic [32:0] SYS_HZ  = 33'(1000000000 / SYS_PRD_NS);
  localparam logic [31:0] HALF_HZ = 32'(SYS_HZ >> 1);
  localparam int unsigned WIN_W   = $clog2(MEAS_WIN_CYC);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(MEAS_WIN_CYC - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [32:0] acc_q, acc_d;
  logic        clk_gen_q, clk_gen_d;
  logic        rise_q, rise_d;
  logic [31:0] active_q, active_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_flag_q, pend_flag_d;
  logic        clamp_q, clamp_d;
  logic [32:0] sum;
  logic        toggle;

  assign sum    = acc_q + {active_q, 1'b0};
  assign toggle = (sum >= SYS_HZ);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    clk_gen_d   = clk_gen_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    clamp_d     = clamp_q;
    case (state_q)
      S_IDLE: begin
        acc_d     = '0;
        clk_gen_d = 1'b0;
        if (pend_flag_q) begin
          pend_flag_d = 1'b0;
          active_d    = pend_q;
          if (pend_q != '0) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (toggle) begin
          acc_d     = sum - SYS_HZ;
          clk_gen_d = ~clk_gen_q;
        end else begin
          acc_d = sum;
        end
        // A falling toggle is the only point a new frequency may take effect.
        if (toggle && clk_gen_q && pend_flag_q) begin
          acc_d       = '0;
          clk_gen_d   = 1'b0;
          active_d    = pend_q;
          pend_flag_d = 1'b0;
          if (pend_q == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A load in the same cycle as an apply becomes the next pending value.
    if (bus.freq_load) begin
      pend_d      = (bus.freq_hz > HALF_HZ) ? HALF_HZ : bus.freq_hz;
      clamp_d     = (bus.freq_hz > HALF_HZ);
      pend_flag_d = 1'b1;
    end
    rise_d = clk_gen_d & ~clk_gen_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      clk_gen_q   <= 1'b0;
      rise_q      <= 1'b0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      clamp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      clk_gen_q   <= clk_gen_d;
      rise_q      <= rise_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      clamp_q     <= clamp_d;
    end
  end

  logic [WIN_W-1:0] win_q;
  logic [31:0]      cnt_q;
  logic [31:0]      cnt_inc;
  logic [31:0]      edge_cnt_q;
  logic             edge_vld_q;

  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'(rise_q);

  // Window runs free from reset; rise_q is the edge seen in the current cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= '0;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      edge_vld_q <= 1'b0;
    end else begin
      edge_vld_q <= 1'b0;
      if (win_q == WIN_LAST) begin
        win_q      <= '0;
        cnt_q      <= '0;
        edge_cnt_q <= cnt_inc;
        edge_vld_q <= 1'b1;
      end else begin
        win_q <= win_q + WIN_W'(1);
        cnt_q <= cnt_inc;
      end
    end
  end

  assign bus.clk_gen        = clk_gen_q;
  assign bus.rise_pulse     = rise_q;
  assign bus.freq_active_hz = active_q;
  assign bus.update_pending = pend_flag_q;
  assign bus.clamp          = clamp_q;
  assign bus.edge_cnt       = edge_cnt_q;
  assign bus.edge_cnt_vld   = edge_vld_q;
  assign bus.state_dbg      = (state_q == S_RUN);
endmodule

// File: tb/tb_freq_gen_value.sv
// Randomized bench for freq_gen_value: toggle-count reference model plus an
// edge-count scoreboard drained by a negedge monitor.
module tb_freq_gen_value;
  localparam longint unsigned H    = 64'd100000000;
  localparam int              W    = 1000;
  localparam logic [31:0]     HALF = 32'd50000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  freq_gen_value_if ifc();

  freq_gen_value #(.SYS_PRD_NS(10), .MEAS_WIN_CYC(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  // Reference model: output level is the parity of floor(k*2F/H) toggles since apply.
  bit              m_run, m_clk, m_rise, m_pflag, m_clamp;
  logic [31:0]     m_f, m_pend, m_cnt;
  longint unsigned m_k;
  int              m_win;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_clk = 0; m_rise = 0; m_pflag = 0; m_clamp = 0;
    m_f = '0; m_pend = '0; m_cnt = '0; m_k = 0; m_win = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit ld;
    logic [31:0] v;
    longint unsigned t_new, t_old;
    bit nclk;
    ld = ifc.freq_load;
    v  = ifc.freq_hz;
    if (m_win == W - 1) begin
      exp_q.push_back(m_cnt + 32'(m_rise));
      m_cnt = '0;
      m_win = 0;
    end else begin
      m_cnt = m_cnt + 32'(m_rise);
      m_win++;
    end
    if (!m_run) begin
      m_clk = 0;
      m_rise = 0;
      if (m_pflag) begin
        m_pflag = 0;
        m_f = m_pend;
        if (m_pend != 0) begin
          m_run = 1;
          m_k = 0;
        end
      end
    end else begin
      m_k++;
      t_new = (m_k * 2 * m_f) / H;
      t_old = ((m_k - 1) * 2 * m_f) / H;
      nclk = t_new[0];
      m_rise = nclk && !m_clk;
      if (t_new != t_old && !nclk && m_pflag) begin
        m_f = m_pend;
        m_k = 0;
        m_pflag = 0;
        if (m_pend == 0) m_run = 0;
      end
      m_clk = nclk;
    end
    if (ld) begin
      m_pend  = (v > HALF) ? HALF : v;
      m_clamp = (v > HALF);
      m_pflag = 1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("clk_gen", ifc.clk_gen, m_clk);
      check("rise_pulse", ifc.rise_pulse, m_rise);
      check("freq_active_hz", ifc.freq_active_hz, m_f);
      check("update_pending", ifc.update_pending, m_pflag);
      check("clamp", ifc.clamp, m_clamp);
      check("state_run", ifc.state_dbg, m_run);
      check("edge_cnt_vld", ifc.edge_cnt_vld, exp_q.size() != 0);
      if (ifc.edge_cnt_vld && exp_q.size() != 0)
        check("edge_cnt", ifc.edge_cnt, exp_q.pop_front());
    end
  end

  task automatic cyc(input bit ld, input logic [31:0] v);
    ifc.freq_load = ld;
    ifc.freq_hz   = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    ifc.freq_load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, $urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_clk_gen"}, ifc.clk_gen, 0);
    check({tag, "_rise"}, ifc.rise_pulse, 0);
    check({tag, "_active"}, ifc.freq_active_hz, 0);
    check({tag, "_pending"}, ifc.update_pending, 0);
    check({tag, "_clamp"}, ifc.clamp, 0);
    check({tag, "_edge_cnt"}, ifc.edge_cnt, 0);
    check({tag, "_edge_vld"}, ifc.edge_cnt_vld, 0);
    check({tag, "_state"}, ifc.state_dbg, 0);
  endtask

  task automatic wait_high();
    int n;
    n = 0;
    while (ifc.clk_gen !== 1'b1 && n < 20) begin
      run(1);
      n++;
    end
    if (n >= 20) check("wait_high_timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] v;
    ifc.freq_load = 1'b0;
    ifc.freq_hz   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(20);

    cyc(1'b1, 32'd25000000);        // 4-cycle period, 250 edges per window
    run(2200);
    cyc(1'b1, 32'd60000000);        // clamped to 50 MHz
    run(2100);
    cyc(1'b1, 32'd25000000);
    run(500);
    wait_high();
    cyc(1'b1, 32'd10000000);        // loaded during the high phase
    run(2100);
    cyc(1'b1, 32'd0);
    run(2100);
    cyc(1'b1, 32'd30000000);
    run(2100);

    for (int i = 0; i < 40; i++) begin
      run($urandom_range(1, 400));
      case ($urandom_range(0, 5))
        0:       v = 32'd0;
        1:       v = $urandom_range(50000000, 90000000);
        2:       v = $urandom_range(1000000, 49999999);
        3:       v = $urandom;
        4:       v = $urandom_range(10000000, 50000000);
        default: v = 32'd25000000;
      endcase
      cyc(1'b1, v);
      if ($urandom_range(0, 3) == 0) cyc(1'b1, $urandom_range(5000000, 50000000));
    end
    run(1100);

    cyc(1'b1, 32'd25000000);
    run(100);
    cyc(1'b1, 32'd10000000);
    #2 rst_n = 1'b0;
    #1 check_zero("midrun_reset");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(50);
    cyc(1'b1, 32'd25000000);
    run(1100);

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
